wb_select_stage: RTL and testbench
==================================

Name: wb_select_stage

Overview:
- Parametrised, registered successor to the single-bit memory-to-register writeback mux.
- Selects one of NUM_SRC WIDTH-bit result sources per instruction and carries the destination register number and write enable alongside it.
- Presents the result through a valid/ready handshake backed by a 2-entry skid buffer, so the register-file write port can stall without dropping or reordering writebacks.
- Sits between the execute/memory result buses and the register file write port.

Parameters:
- WIDTH, 32, data width of each source and of the output.
- NUM_SRC, 9, number of selectable sources (legal sel range 0..NUM_SRC-1).
- SEL_W, 4, select width; must satisfy 2^SEL_W >= NUM_SRC.
- RA_W, 5, destination register address width.
- ZERO_GUARD, 1, when 1 a write to register 0 has its write enable forced to 0.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has a writeback request.
- in_ready  output  1  stage can accept a request this cycle.
- src_data  input  NUM_SRC*WIDTH  packed sources; source k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  source index.
- in_rd  input  RA_W  destination register.
- in_we  input  1  write enable requested.
- out_valid  output  1  out_* fields are valid.
- out_ready  input  1  downstream accepts this cycle.
- out_data  output  WIDTH  selected result.
- out_rd  output  RA_W  destination register.
- out_we  output  1  effective write enable.
- sel_err  output  1  sticky flag, set by any accepted request with an illegal sel.
- err_clr  input  1  synchronous clear of sel_err.

Behaviour:
- Reset (reset_n=0, asynchronous):
  - out_valid=0, out_data=0, out_rd=0, out_we=0, sel_err=0.
  - Skid entry is emptied.
  - in_ready=1 from the first clock edge after release; it is combinationally !skid_valid, so it also reads 1 while reset is asserted.
  - Reset mid-transfer discards both entries; nothing is replayed.
- Accept and release conditions:
  - A request is accepted on a rising edge where in_valid && in_ready.
  - An output entry is released on a rising edge where out_valid && out_ready.
- Per accepted request, the entry is computed combinationally from the inputs at the accept edge:
  - If sel < NUM_SRC: data = src_data[sel*WIDTH +: WIDTH], we = in_we.
  - If sel >= NUM_SRC: data = 0, we = 0, and sel_err is set on that edge.
  - If ZERO_GUARD==1 and in_rd==0: we = 0; data and rd are still passed through.
- Storage: main output register (out_*) plus one skid register.
  - in_ready = !skid_valid.
  - Main empty, or main released this edge while skid empty: the accepted entry loads main directly. Latency is 1 cycle from accept to out_valid.
  - Main full and not released: the accepted entry goes to skid.
  - Main released while skid full: skid moves to main. A simultaneous accept is impossible because in_ready=0.
  - Main released with no replacement: out_valid falls to 0. out_data, out_rd and out_we hold their last values and are don't-care when out_valid=0.
- Throughput is 1 request/cycle with out_ready held high. Order is strictly FIFO; there are never more than 2 entries in flight.
- Stability: while out_valid && !out_ready, all out_* fields must not change.
- sel_err:
  - Set on an illegal-sel accept; cleared by err_clr on the same edge only if no illegal accept occurs on that edge (set wins).
  - A request with in_valid=0 never affects sel_err.
- src_data, sel, in_rd and in_we are sampled only on accept edges; their values at other times have no effect.

Test Plan:
- Reset then single write: in_valid=1, sel=3, src3=0xDEADBEEF, in_rd=7, in_we=1, out_ready=1 -> next cycle out_valid=1, out_data=0xDEADBEEF, out_rd=7, out_we=1; following cycle out_valid=0.
- Back-to-back stream: sel=0..8 on consecutive cycles, source k=0x100+k, out_ready=1 -> outputs 0x100..0x108 on 9 consecutive cycles, in_ready constantly 1.
- Backpressure: out_ready=0, send requests A=sel1 and B=sel2 -> out holds A and in_ready falls to 0 after B; a third request C is not accepted; raise out_ready -> A, B, C delivered in order with no loss or duplication.
- Illegal select: sel=12 with NUM_SRC=9, in_we=1 -> out_data=0, out_we=0, sel_err=1 and stays 1; pulse err_clr with no illegal accept on that edge -> sel_err=0; err_clr on the same edge as a sel=15 accept -> sel_err stays 1.
- Zero guard: in_rd=0, in_we=1, sel=2 -> out_we=0, out_data=src2; with ZERO_GUARD=0 -> out_we=1.
- Async reset mid-stall: 2 entries held with out_ready=0, drop reset_n between clock edges -> out_valid=0 and sel_err=0 immediately; after release, in_ready=1 and no stale entry appears.

Source files
------------

// File: rtl/wb_select_stage.sv
// Writeback select stage: picks one of NUM_SRC result sources and carries rd/we to the register-file write port.
// Latency: 1 cycle from accept to out_valid. Sustains 1 request/cycle while out_ready stays high.
// Backpressure: a 2-entry main+skid buffer absorbs one stall cycle; in_ready drops only while the skid entry is occupied.
module wb_select_stage #(
    parameter int WIDTH      = 32,
    parameter int NUM_SRC    = 9,
    parameter int SEL_W      = 4,
    parameter int RA_W       = 5,
    parameter bit ZERO_GUARD = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset_n,

    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [NUM_SRC*WIDTH-1:0] src_data,
    input  logic [SEL_W-1:0]         sel,
    input  logic [RA_W-1:0]          in_rd,
    input  logic                     in_we,

    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [WIDTH-1:0]         out_data,
    output logic [RA_W-1:0]          out_rd,
    output logic                     out_we,

    output logic                     sel_err,
    input  logic                     err_clr
);

    // One writeback entry as it travels through the buffer.
    typedef struct packed {
        logic [WIDTH-1:0] data;
        logic [RA_W-1:0]  rd;
        logic             we;
    } entry_t;

    // Main (presented) register and skid register.
    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   out_valid_q, out_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   sel_err_q, sel_err_d;

    logic             accept;
    logic             release_out;
    logic             sel_legal;
    logic [WIDTH-1:0] mux_data;
    entry_t           new_entry;

    // The skid entry is the only reason to refuse a request.
    assign in_ready    = !skid_valid_q;
    assign accept      = in_valid && in_ready;
    assign release_out = out_valid_q && out_ready;
    assign sel_legal   = (int'(sel) < NUM_SRC);

    // Source mux; an out-of-range select yields zero rather than an arbitrary slice.
    always_comb begin
        mux_data = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (int'(sel) == k) begin
                mux_data = src_data[k*WIDTH +: WIDTH];
            end
        end
    end

    // Build the entry for this cycle's request; writes to r0 are suppressed when guarded.
    always_comb begin
        new_entry      = '0;
        new_entry.data = mux_data;
        new_entry.rd   = in_rd;
        new_entry.we   = in_we && sel_legal && !(ZERO_GUARD && (in_rd == '0));
    end

    // Next-state for the two-entry buffer and the sticky select-error flag.
    always_comb begin
        main_d       = main_q;
        skid_d       = skid_q;
        out_valid_d  = out_valid_q;
        skid_valid_d = skid_valid_q;
        sel_err_d    = sel_err_q;

        // Drain: refill main from skid, otherwise main goes empty (fields hold).
        if (release_out) begin
            if (skid_valid_q) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end else begin
                out_valid_d  = 1'b0;
            end
        end

        // Fill: accept implies skid is empty, so a released main is always free here.
        if (accept) begin
            if (!out_valid_q || release_out) begin
                main_d       = new_entry;
                out_valid_d  = 1'b1;
            end else begin
                skid_d       = new_entry;
                skid_valid_d = 1'b1;
            end
        end

        // A set on the same edge beats a clear.
        if (accept && !sel_legal) begin
            sel_err_d = 1'b1;
        end else if (err_clr) begin
            sel_err_d = 1'b0;
        end
    end

    // State registers; reset discards any in-flight entries.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            main_q       <= '0;
            skid_q       <= '0;
            out_valid_q  <= 1'b0;
            skid_valid_q <= 1'b0;
            sel_err_q    <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            out_valid_q  <= out_valid_d;
            skid_valid_q <= skid_valid_d;
            sel_err_q    <= sel_err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = main_q.data;
    assign out_rd    = main_q.rd;
    assign out_we    = main_q.we;
    assign sel_err   = sel_err_q;

endmodule

// File: tb/tb_wb_select_stage.sv
// Testbench for wb_select_stage: directed scenarios followed by randomized traffic.
// Two instances share stimulus, one with the r0 write guard on and one with it off.
// Expected entries are queued at issue time and popped by an independent output monitor.
module tb_wb_select_stage;

    localparam int W  = 32;
    localparam int N  = 9;
    localparam int SW = 4;
    localparam int RW = 5;

    logic            clk;
    logic            reset_n;
    logic            in_valid;
    logic [N*W-1:0]  src_data;
    logic [SW-1:0]   sel;
    logic [RW-1:0]   in_rd;
    logic            in_we;
    logic            out_ready;
    logic            err_clr;

    logic            in_ready_g,  in_ready_n;
    logic            out_valid_g, out_valid_n;
    logic [W-1:0]    out_data_g,  out_data_n;
    logic [RW-1:0]   out_rd_g,    out_rd_n;
    logic            out_we_g,    out_we_n;
    logic            sel_err_g,   sel_err_n;

    wb_select_stage u_dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready_g), .src_data(src_data),
        .sel(sel), .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid_g), .out_ready(out_ready), .out_data(out_data_g),
        .out_rd(out_rd_g), .out_we(out_we_g),
        .sel_err(sel_err_g), .err_clr(err_clr)
    );

    wb_select_stage #(.ZERO_GUARD(1'b0)) u_dut_nz (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready_n), .src_data(src_data),
        .sel(sel), .in_rd(in_rd), .in_we(in_we),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
        .out_rd(out_rd_n), .out_we(out_we_n),
        .sel_err(sel_err_n), .err_clr(err_clr)
    );

    typedef struct {
        logic [W-1:0]  data;
        logic [RW-1:0] rd;
        logic          we_g;   // guarded instance
        logic          we_n;   // unguarded instance
    } exp_t;

    exp_t          q[$];
    logic [W-1:0]  srcs [N];
    logic          err_m;
    logic          exp_rdy;
    int            n_tests;
    int            n_fail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Output monitor: mid-cycle, compares both instances against the model queue.
    initial begin
        exp_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            if (!reset_n) begin
                exp_rdy = 1'b1;
            end else begin
                chk("in_ready_g",  in_ready_g,  q.size() < 2);
                chk("in_ready_n",  in_ready_n,  q.size() < 2);
                chk("sel_err_g",   sel_err_g,   err_m);
                chk("sel_err_n",   sel_err_n,   err_m);
                chk("out_valid_g", out_valid_g, q.size() != 0);
                chk("out_valid_n", out_valid_n, q.size() != 0);
                if (q.size() != 0 && out_valid_g && out_valid_n) begin
                    chk("out_data_g", out_data_g, q[0].data);
                    chk("out_rd_g",   out_rd_g,   q[0].rd);
                    chk("out_we_g",   out_we_g,   q[0].we_g);
                    chk("out_data_n", out_data_n, q[0].data);
                    chk("out_rd_n",   out_rd_n,   q[0].rd);
                    chk("out_we_n",   out_we_n,   q[0].we_n);
                end
                exp_rdy = (q.size() < 2);
                if (q.size() != 0 && out_ready) begin
                    void'(q.pop_front());
                end
            end
        end
    end

    // Drive one cycle of stimulus and record the expected result if it is accepted.
    task automatic step(input logic v, input logic [SW-1:0] s, input logic [RW-1:0] rd,
                        input logic we, input logic clr, input logic ordy, output logic acc);
        exp_t e;
        logic legal;
        @(posedge clk);
        #1;
        in_valid  = v;
        sel       = s;
        in_rd     = rd;
        in_we     = we;
        err_clr   = clr;
        out_ready = ordy;
        for (int k = 0; k < N; k++) src_data[k*W +: W] = srcs[k];
        #2;
        acc   = v && exp_rdy;
        legal = (int'(s) < N);
        if (acc) begin
            e.data = '0;
            if (legal) e.data = srcs[int'(s)];
            e.rd   = rd;
            e.we_n = legal && we;
            e.we_g = legal && we && (rd != '0);
            q.push_back(e);
        end
        if (acc && !legal) err_m = 1'b1;
        else if (clr)      err_m = 1'b0;
    endtask

    task automatic idle(input int n);
        logic a;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, a);
    endtask

    // Assert reset between edges and check the outputs clear without waiting for a clock.
    task automatic async_reset();
        @(posedge clk);
        #1;
        in_valid = 1'b0; out_ready = 1'b0; err_clr = 1'b0;
        #3;
        reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid_g, 1'b0);
        chk("rst_sel_err",   sel_err_g,   1'b0);
        chk("rst_in_ready",  in_ready_g,  1'b1);
        chk("rst_out_data",  out_data_g,  '0);
        chk("rst_out_we",    out_we_g,    1'b0);
        chk("rst_nz_valid",  out_valid_n, 1'b0);
        q.delete();
        err_m = 1'b0;
        @(posedge clk);
        #4;
        reset_n = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic a;
        logic [SW-1:0] s;
        n_tests = 0; n_fail = 0; err_m = 1'b0;
        reset_n = 1'b0; in_valid = 1'b0; sel = '0; in_rd = '0; in_we = 1'b0;
        out_ready = 1'b0; err_clr = 1'b0; src_data = '0;
        for (int k = 0; k < N; k++) srcs[k] = 32'h0;

        // Reset values while reset is held.
        #2;
        chk("reset_out_valid", out_valid_g, 1'b0);
        chk("reset_out_data",  out_data_g,  '0);
        chk("reset_out_rd",    out_rd_g,    '0);
        chk("reset_out_we",    out_we_g,    1'b0);
        chk("reset_sel_err",   sel_err_g,   1'b0);
        chk("reset_in_ready",  in_ready_g,  1'b1);
        #12;
        reset_n = 1'b1;

        // Single write.
        srcs[3] = 32'hDEADBEEF;
        step(1'b1, 4'd3, 5'd7, 1'b1, 1'b0, 1'b1, a);
        idle(2);

        // Back-to-back stream over every legal source.
        for (int k = 0; k < N; k++) srcs[k] = 32'h100 + k;
        for (int k = 0; k < N; k++) step(1'b1, SW'(k), RW'(k + 1), 1'b1, 1'b0, 1'b1, a);
        idle(2);

        // Backpressure: A and B fill the buffer, C must wait.
        step(1'b1, 4'd1, 5'd10, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 4'd2, 5'd11, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 4'd4, 5'd12, 1'b1, 1'b0, 1'b0, a);
        chk("c_refused", a, 1'b0);
        step(1'b1, 4'd4, 5'd12, 1'b1, 1'b0, 1'b0, a);
        a = 1'b0;
        for (int i = 0; i < 10 && !a; i++) step(1'b1, 4'd4, 5'd12, 1'b1, 1'b0, 1'b1, a);
        chk("c_accepted", a, 1'b1);
        idle(3);

        // Illegal selects and sticky error behaviour.
        step(1'b1, 4'd12, 5'd3, 1'b1, 1'b0, 1'b1, a);
        idle(2);
        step(1'b0, 4'd15, 5'd3, 1'b1, 1'b0, 1'b1, a);
        step(1'b0, 4'd0, 5'd0, 1'b0, 1'b1, 1'b1, a);
        idle(1);
        step(1'b1, 4'd12, 5'd3, 1'b1, 1'b0, 1'b1, a);
        step(1'b1, 4'd15, 5'd3, 1'b1, 1'b1, 1'b1, a);
        idle(2);

        // Writes to r0 with and without the guard.
        step(1'b1, 4'd2, 5'd0, 1'b1, 1'b0, 1'b1, a);
        idle(2);

        // Reset while two entries are stalled.
        step(1'b1, 4'd13, 5'd5, 1'b1, 1'b0, 1'b0, a);
        step(1'b1, 4'd6, 5'd6, 1'b1, 1'b0, 1'b0, a);
        step(1'b0, 4'd0, 5'd0, 1'b0, 1'b0, 1'b0, a);
        async_reset();
        idle(3);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            for (int k = 0; k < N; k++) srcs[k] = $urandom;
            if ($urandom_range(7) == 0) s = SW'(N + $urandom_range(15 - N));
            else                        s = SW'($urandom_range(N - 1));
            step($urandom_range(3) != 0, s, RW'($urandom), 1'(($urandom)),
                 $urandom_range(15) == 0, $urandom_range(2) != 0, a);
        end

        // Drain with a bounded wait.
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        chk("drain_empty", q.size(), 0);
        idle(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
